// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared raster timing definitions for the timing generator and the pixel
// renderers: default 640x480@60 timing (800x525 total on a 25 MHz pixel
// clock), the derived totals, and the 10-bit coordinate type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_VIS      = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_VIS      = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SYNC_DELAY = 2;

    localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Both totals must fit in this type (<= 1024).
    typedef logic [9:0] coord_t;

    // Inclusive range test used for the sync pulse decodes.
    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of raster timing signals between the timing generator (master) and
// the renderers (slave).
//   pix_ce       pixel clock-enable into the generator
//   DrawX/DrawY  current pixel coordinates
//   blank        1 while the pixel is visible
//   hs/vs        active-low syncs
//   line_start   one-cycle pulse when DrawX becomes 0
//   frame_start  one-cycle pulse when DrawX=0 and DrawY=0
//   frame_count  frames started since reset (wraps)
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic       pix_ce;
    coord_t     DrawX;
    coord_t     DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  pix_ce,
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input  pix_ce, DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

endinterface

// File: rtl/vga_sync_delay.sv
// -----------------------------------------------------------------------------
// vga_sync_delay
// DEPTH-stage shift register, advanced only when i_ce=1, every stage resetting
// to all ones (the inactive level of active-low syncs).
//   clk   clock
//   rst   asynchronous active-high reset
//   i_ce  shift enable
//   i_d   data in (WIDTH bits)
//   o_q   data out, DEPTH enabled cycles behind i_d
// -----------------------------------------------------------------------------
module vga_sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;
    logic [DEPTH-1:0][WIDTH-1:0] w_stage_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_stage_next[gi] = i_d;
            end else begin : g_tail
                assign w_stage_next[gi] = r_stage[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '1;
        end else if (i_ce) begin
            r_stage <= w_stage_next;
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator: pixel coordinates, visible-area flag, active-low
// syncs and line/frame markers, advancing once per pix_ce.
// Ports:
//   vga_clk  pixel clock
//   reset    asynchronous active-high reset (parks on the last pixel of the
//            frame, so the first enabled edge lands on pixel 0,0)
//   vif      vga_timing_gen_if.master (pix_ce in, timing signals out)
// Configuration macro VGA_SYNC_ALIGN_EN: when defined, hs/vs are delayed by
// SYNC_DELAY (1..7) enabled cycles to line up with the renderer pipeline;
// when undefined, hs/vs are aligned with DrawX/DrawY and there is no
// SYNC_DELAY parameter.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP
`ifdef VGA_SYNC_ALIGN_EN
    , parameter int SYNC_DELAY = DEF_SYNC_DELAY
`endif
) (
    input  logic vga_clk,
    input  logic reset,
    vga_timing_gen_if.master vif
);

    localparam int LINE_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;

    localparam coord_t X_LAST   = coord_t'(LINE_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(FRAME_LINES - 1);
    localparam coord_t X_VIS    = coord_t'(H_VIS);
    localparam coord_t Y_VIS    = coord_t'(V_VIS);
    localparam coord_t HS_FIRST = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_VIS + V_FP + V_SYNC - 1);

    coord_t     r_x;
    coord_t     r_y;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    coord_t     w_x_next;
    coord_t     w_y_next;
    logic       w_x_wrap;
    logic       w_blank_next;
    logic       w_hs_next;
    logic       w_vs_next;
    logic       w_line_next;
    logic       w_frame_next;

    // Decode from the next-state coordinates so the registered flags describe
    // the same pixel as the registered DrawX/DrawY.
    always_comb begin
        w_x_wrap = (r_x == X_LAST);
        w_x_next = w_x_wrap ? '0 : r_x + coord_t'(1);
        w_y_next = r_y;
        if (w_x_wrap) begin
            w_y_next = (r_y == Y_LAST) ? '0 : r_y + coord_t'(1);
        end
        w_blank_next = (w_x_next < X_VIS) && (w_y_next < Y_VIS);
        w_hs_next    = !in_range(w_x_next, HS_FIRST, HS_LAST);
        w_vs_next    = !in_range(w_y_next, VS_FIRST, VS_LAST);
        w_line_next  = (w_x_next == '0);
        w_frame_next = w_line_next && (w_y_next == '0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_x           <= X_LAST;
            r_y           <= Y_LAST;
            r_blank       <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else if (vif.pix_ce) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_blank       <= w_blank_next;
            r_hs          <= w_hs_next;
            r_vs          <= w_vs_next;
            r_line_start  <= w_line_next;
            r_frame_start <= w_frame_next;
            if (w_frame_next) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end else begin
            // Markers are strobes: they must not stretch across stalled cycles.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vif.DrawX       = r_x;
    assign vif.DrawY       = r_y;
    assign vif.blank       = r_blank;
    assign vif.line_start  = r_line_start;
    assign vif.frame_start = r_frame_start;
    assign vif.frame_count = r_frame_count;

`ifdef VGA_SYNC_ALIGN_EN
    logic [1:0] w_sync_dly;

    vga_sync_delay #(
        .WIDTH (2),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .clk  (vga_clk),
        .rst  (reset),
        .i_ce (vif.pix_ce),
        .i_d  ({r_hs, r_vs}),
        .o_q  (w_sync_dly)
    );

    assign vif.hs = w_sync_dly[1];
    assign vif.vs = w_sync_dly[0];
`else
    assign vif.hs = r_hs;
    assign vif.vs = r_vs;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen on a reduced raster (16x12 total:
// visible 8x6, hsync at x 10..12, vsync at y 8..9) so full frames and the
// frame_count wrap stay short. Expected sync values depend on
// VGA_SYNC_ALIGN_EN (default SYNC_DELAY of 2 when defined).
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VV = 6, VF = 2, VSW = 2, VB = 2;
    localparam int HT = HV + HF + HSW + HB;   // 16
    localparam int VT = VV + VF + VSW + VB;   // 12
    localparam int FRAME = HT * VT;           // 192

`ifdef VGA_SYNC_ALIGN_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_gen_if vif();

    vga_timing_gen #(
        .H_VIS (HV), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB)
    ) dut (
        .vga_clk (clk),
        .reset   (rst),
        .vif     (vif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // k = number of pix_ce=1 edges since reset release.
    // hs_d/vs_d are the values expected with the two-stage sync delay.
    typedef struct {
        int k;
        int x;
        int y;
        bit blank;
        bit hs;
        bit hs_d;
        bit vs;
        bit vs_d;
        bit ls;
        bit fs;
        int fc;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        vif.pix_ce = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int cur;
        int gap;
        int cnt;
        int first_low;
        int first_blank;
        int bad;
        int edges;
        bit e_hs;
        bit e_vs;
        vec_t v;

        //            k    x   y  b hs hd vs vd ls fs fc
        vecs[0]  = '{  0, 15, 11, 0, 1, 1, 1, 1, 0, 0, 0};
        vecs[1]  = '{  1,  0,  0, 1, 1, 1, 1, 1, 1, 1, 1};
        vecs[2]  = '{  2,  1,  0, 1, 1, 1, 1, 1, 0, 0, 1};
        vecs[3]  = '{  8,  7,  0, 1, 1, 1, 1, 1, 0, 0, 1};
        vecs[4]  = '{  9,  8,  0, 0, 1, 1, 1, 1, 0, 0, 1};
        vecs[5]  = '{ 11, 10,  0, 0, 0, 1, 1, 1, 0, 0, 1};
        vecs[6]  = '{ 13, 12,  0, 0, 0, 0, 1, 1, 0, 0, 1};
        vecs[7]  = '{ 14, 13,  0, 0, 1, 0, 1, 1, 0, 0, 1};
        vecs[8]  = '{ 15, 14,  0, 0, 1, 0, 1, 1, 0, 0, 1};
        vecs[9]  = '{ 16, 15,  0, 0, 1, 1, 1, 1, 0, 0, 1};
        vecs[10] = '{ 17,  0,  1, 1, 1, 1, 1, 1, 1, 0, 1};
        vecs[11] = '{ 97,  0,  6, 0, 1, 1, 1, 1, 1, 0, 1};
        vecs[12] = '{129,  0,  8, 0, 1, 1, 0, 1, 1, 0, 1};
        vecs[13] = '{131,  2,  8, 0, 1, 1, 0, 0, 0, 0, 1};
        vecs[14] = '{160, 15,  9, 0, 1, 1, 0, 0, 0, 0, 1};
        vecs[15] = '{161,  0, 10, 0, 1, 1, 1, 0, 1, 0, 1};
        vecs[16] = '{193,  0,  0, 1, 1, 1, 1, 1, 1, 1, 2};

        // ---------------- table-driven raster walk ----------------
        do_reset();
        cur = 0;
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            while (cur < v.k) begin
                vif.pix_ce = 1'b1;
                tick();
                cur++;
            end
            e_hs = (DLY != 0) ? v.hs_d : v.hs;
            e_vs = (DLY != 0) ? v.vs_d : v.vs;
            check($sformatf("k%0d DrawX", v.k),       vif.DrawX,       v.x);
            check($sformatf("k%0d DrawY", v.k),       vif.DrawY,       v.y);
            check($sformatf("k%0d blank", v.k),       vif.blank,       v.blank);
            check($sformatf("k%0d hs", v.k),          vif.hs,          e_hs);
            check($sformatf("k%0d vs", v.k),          vif.vs,          e_vs);
            check($sformatf("k%0d line_start", v.k),  vif.line_start,  v.ls);
            check($sformatf("k%0d frame_start", v.k), vif.frame_start, v.fs);
            check($sformatf("k%0d frame_count", v.k), vif.frame_count, v.fc);
            $display("vec k=%0d DrawX=%0d DrawY=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                     v.k, vif.DrawX, vif.DrawY, vif.blank, vif.hs, vif.vs,
                     vif.line_start, vif.frame_start, vif.frame_count);
        end

        // ---------------- frame_start period ----------------
        do_reset();
        vif.pix_ce = 1'b1;
        tick();
        check("first_frame_start", vif.frame_start, 1);
        gap = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            gap++;
            if (vif.frame_start) break;
        end
        check("frame_start_period", gap, FRAME);
        $display("seq frame period: %0d cycles", gap);

        // ---------------- line 0 sweep: blank edge and hsync window ----------------
        do_reset();
        vif.pix_ce = 1'b1;
        cnt = 0;
        first_low = -1;
        first_blank = -1;
        for (int i = 0; i < HT; i++) begin
            tick();
            if (vif.hs === 1'b0) begin
                cnt++;
                if (first_low < 0) first_low = vif.DrawX;
            end
            if (vif.blank === 1'b0 && first_blank < 0) first_blank = vif.DrawX;
        end
        check("line_blank_fall_x", first_blank, HV);
        check("line_hs_fall_x", first_low, HV + HF + DLY);
        check("line_hs_low_cycles", cnt, HSW);
        $display("seq line sweep: blank falls x=%0d, hs falls x=%0d, low %0d", first_blank, first_low, cnt);

        // ---------------- frame sweep: vsync length and blanking below visible ----------------
        do_reset();
        vif.pix_ce = 1'b1;
        cnt = 0;
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (vif.vs === 1'b0) cnt++;
            if (vif.DrawY >= VV && vif.blank !== 1'b0) bad++;
        end
        check("frame_vs_low_cycles", cnt, VSW * HT);
        check("frame_blank_below_visible", bad, 0);
        $display("seq frame sweep: vs low %0d cycles, blank errors %0d", cnt, bad);

        // ---------------- pix_ce toggling ----------------
        do_reset();
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            vif.pix_ce = ((i % 2) == 0);
            tick();
            if (vif.pix_ce) edges++;
            check($sformatf("toggle%0d DrawX", i), vif.DrawX, (edges - 1) % HT);
            check($sformatf("toggle%0d line_start", i), vif.line_start,
                  (vif.pix_ce && ((edges - 1) % HT) == 0));
            check($sformatf("toggle%0d frame_start", i), vif.frame_start,
                  (vif.pix_ce && edges == 1));
        end
        $display("seq pix_ce toggle: %0d enabled edges", edges);

        // ---------------- asynchronous reset mid-frame (x=12, y=8) ----------------
        do_reset();
        vif.pix_ce = 1'b1;
        repeat (8 * HT + 12 + 1) tick();
        check("pre_reset DrawX", vif.DrawX, 12);
        check("pre_reset DrawY", vif.DrawY, 8);
        check("pre_reset hs", vif.hs, 0);
        check("pre_reset vs", vif.vs, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midreset DrawX", vif.DrawX, HT - 1);
        check("midreset DrawY", vif.DrawY, VT - 1);
        check("midreset blank", vif.blank, 0);
        check("midreset hs", vif.hs, 1);
        check("midreset vs", vif.vs, 1);
        check("midreset line_start", vif.line_start, 0);
        check("midreset frame_start", vif.frame_start, 0);
        check("midreset frame_count", vif.frame_count, 0);
        $display("seq mid-frame reset: DrawX=%0d DrawY=%0d fc=%0d", vif.DrawX, vif.DrawY, vif.frame_count);
        tick();
        rst = 1'b0;

        // ---------------- frame_count wrap after 256 frames ----------------
        do_reset();
        vif.pix_ce = 1'b1;
        repeat (1 + FRAME * 254) tick();
        check("wrap fc_255", vif.frame_count, 255);
        check("wrap fs_255", vif.frame_start, 1);
        repeat (FRAME) tick();
        check("wrap fc_0", vif.frame_count, 0);
        check("wrap fs_0", vif.frame_start, 1);
        $display("seq frame_count wrap: fc=%0d", vif.frame_count);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
